uart_tx: RTL and testbench

UART_TX -- requirements
Module: UART_TX

---
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Serial transmitter. Sends one frame per accepted word, one
//               bit per clock: a start bit (0), IN_width data bits LSB first,
//               an optional parity bit and a stop bit (1). The word and its
//               parity configuration are captured when the word is accepted,
//               so later input changes cannot disturb a frame already on the
//               line.
// Ports       :
//   CLK        in   1         rising-edge clock
//   RST        in   1         synchronous reset, active low
//   P_DATA     in   IN_width  word to send; captured on acceptance
//   DATA_VALID in   1         request; accepted only while idle
//   PAR_EN     in   1         1 = add a parity bit; captured on acceptance
//   PAR_TYP    in   1         1 = odd parity, 0 = even; captured on acceptance
//   TX_OUT     out  1         serial line, registered, idles high
//   busy       out  1         registered, high while a frame is on the line
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int IN_width = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [IN_width-1:0] P_DATA,
  input  logic                DATA_VALID,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  output logic                TX_OUT,
  output logic                busy
);

  // Width of the bit counter that walks the data bits.
  localparam int c_cnt_w = (IN_width > 1) ? $clog2(IN_width) : 1;
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(IN_width - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t              state_q,   state_d;
  logic [c_cnt_w-1:0]  cnt_q,     cnt_d;
  logic [IN_width-1:0] data_q,    data_d;
  logic                par_en_q,  par_en_d;
  logic                par_typ_q, par_typ_d;
  logic                tx_q,      tx_d;
  logic                busy_q,    busy_d;

  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic                w_parity;

  assign w_cnt_nxt = cnt_q + 1'b1;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  assign w_parity = par_typ_q ? ~(^data_q) : (^data_q);

  // --------------------------------------------------------------------------
  // Next-state logic. The line and busy flops are loaded with the value that
  // belongs to the state being entered, so each bit appears on TX_OUT in the
  // cycle right after the edge that selects it and both outputs come straight
  // from flops.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (DATA_VALID) begin
          state_d   = ST_START;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end

      ST_DATA: begin
        if (cnt_q == c_last_bit) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = ST_PARITY;
            tx_d    = w_parity;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = w_cnt_nxt;
          tx_d  = data_q[w_cnt_nxt];
        end
      end

      ST_PARITY: begin
        state_d = ST_STOP;
        tx_d    = 1'b1;
      end

      ST_STOP: begin
        // Returning to idle drops busy for at least one cycle, which
        // guarantees a gap before the next start bit even when DATA_VALID
        // is held high.
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register. Reset wins over everything and aborts a frame mid-flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Expected frames come from a
//               bit-list model built from the framing rules (start, data LSB
//               first, parity from a count of ones, stop).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.IN_width(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference frame: element k is the line level k cycles after acceptance.
  task automatic build_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             output logic [15:0] frame, output int len);
    int ones;
    logic par;
    ones  = $countones(d);
    frame = '1;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[1 + i] = d[i];
    // Parity bit makes the total count of ones even (ptyp=0) or odd (ptyp=1).
    if (ptyp) par = ((ones % 2) == 0);
    else      par = ((ones % 2) == 1);
    if (pen) begin
      frame[9]  = par;
      frame[10] = 1'b1;
      len = 11;
    end else begin
      frame[9] = 1'b1;
      len = 10;
    end
  endtask

  // Offer a word, then follow the frame bit by bit. disturb=1 re-asserts
  // DATA_VALID with 8'h55 mid-frame and leaves it held; abort_at>=0 pulses
  // reset while frame element abort_at is on the line.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input bit disturb, input int abort_at,
                            output logic [15:0] obs);
    logic [15:0] expf;
    int len;
    build_frame(d, pen, ptyp, expf, len);
    obs = '1;
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    for (int k = 0; k < len; k++) begin
      obs[k] = TX_OUT;
      check("tx_bit", {15'd0, TX_OUT}, {15'd0, expf[k]});
      check("busy_hi", {15'd0, busy}, 16'd1);
      if (k == abort_at) begin
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("abort_tx", {15'd0, TX_OUT}, 16'd1);
        check("abort_busy", {15'd0, busy}, 16'd0);
        return;
      end
      if (disturb && k >= 3) begin
        DATA_VALID = 1'b1; P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      end else if (k >= 1) begin
        P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      end
      tick();
    end
    check("idle_tx", {15'd0, TX_OUT}, 16'd1);
    check("idle_busy", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic [15:0] obs;
    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;

    // Reset state.
    tick(); tick();
    check("rst_tx", {15'd0, TX_OUT}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);

    // Reset has priority over a request.
    DATA_VALID = 1'b1; P_DATA = 8'hF9;
    tick();
    check("rst_prio_tx", {15'd0, TX_OUT}, 16'd1);
    check("rst_prio_busy", {15'd0, busy}, 16'd0);
    DATA_VALID = 1'b0;
    RST = 1'b1;
    tick();
    check("post_rst_idle", {15'd0, busy}, 16'd0);

    // No parity, 8'hF9.
    send_frame(8'hF9, 1'b0, 1'b0, 1'b0, -1, obs);
    check("seq_f9_nopar", {6'd0, obs[9:0]}, 16'h03F2);

    // Odd parity, 8'hF9 -> parity 1.
    send_frame(8'hF9, 1'b1, 1'b1, 1'b0, -1, obs);
    check("seq_f9_odd", {5'd0, obs[10:0]}, 16'h07F2);

    // Even parity, 8'hF9 -> parity 0.
    send_frame(8'hF9, 1'b1, 1'b0, 1'b0, -1, obs);
    check("seq_f9_even", {5'd0, obs[10:0]}, 16'h05F2);

    // Odd parity, 8'h00 -> parity 1.
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, -1, obs);
    check("seq_00_odd", {5'd0, obs[10:0]}, 16'h0600);

    // Mid-frame request with new data is ignored; the held request starts
    // the 8'h55 frame only after one idle cycle (checked at the end of the
    // first call, accepted on the first edge of the second).
    send_frame(8'hF9, 1'b1, 1'b0, 1'b1, -1, obs);
    check("seq_disturbed", {5'd0, obs[10:0]}, 16'h05F2);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, obs);

    // Reset during data bit 4 (frame element 5), then a clean 8'hA5 frame.
    send_frame(8'hF9, 1'b0, 1'b0, 1'b0, 5, obs);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, -1, obs);
    check("seq_a5_after_rst", {6'd0, obs[9:0]}, 16'h034A);

    // Random words and parity settings against the model.
    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, -1, obs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
